// File: rtl/tropang_rom_loader.sv
// Purpose : routes the HPS ioctl ROM stream into SDRAM ports 1/2 and the on-chip dl_* bus using the Tropical Angel map.
// Latency : dl writes appear 1 cycle after the ioctl_wr rise; SDRAM req toggles 2 cycles after it (3-cycle turnaround minimum).
// Backpr. : ioctl_wait is high from the cycle after an SDRAM byte is taken until its ack (or timeout) returns the FSM to IDLE.
//
// Ports:
//   clk_mem, reset_n (async, active-low)
//   ioctl_download/wr/addr/dout/index in, ioctl_wait out
//   port1_* / port2_* : toggle req/ack SDRAM write ports (word address, byte enables, duplicated byte data)
//   dl_addr/dl_data/dl_wr : on-chip write bus for gfx1 and palette/LUT
//   rom_loaded, load_err : status
// Optional: define TROPANG_LOADER_CHECKSUM_EN to add the 16-bit checksum output.
module tropang_rom_loader #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk_mem,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [7:0]  ioctl_index,
  output logic        ioctl_wait,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [22:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic [16:0] dl_addr,
  output logic [7:0]  dl_data,
  output logic        dl_wr,
  output logic        rom_loaded,
  output logic        load_err
`ifdef TROPANG_LOADER_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_t;

  // The timeout fires on the ACK_TIMEOUT-th WAIT_ACK cycle, i.e. ACK_TIMEOUT
  // cycles after the req toggle becomes visible.
  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        wr_d, download_d, sel_p2, end_pend;
  logic [7:0]  to_cnt;
  logic [16:0] a;
  logic [23:0] s;
  logic        hi_ok, in_p1, in_p2, in_dl;
  logic        wr_take, dl_rise, dl_fall;
  logic        cur_req, cur_ack;
  logic        go_dl, go_p1, go_p2, do_issue, do_abandon, proto_err;

  assign a       = ioctl_addr[16:0];
  assign s       = ioctl_addr[23:0] - 24'h01_0000;
  assign hi_ok   = (ioctl_addr[24:17] == 8'd0);
  assign in_p1   = hi_ok && (a < 17'h0A000);
  assign in_p2   = hi_ok && (a >= 17'h10000) && (a < 17'h1C000);
  assign in_dl   = hi_ok && (((a >= 17'h0A000) && (a < 17'h10000)) ||
                             ((a >= 17'h1C000) && (a <= 17'h1C31F)));
  assign wr_take = ioctl_wr && !wr_d && ioctl_download && (ioctl_index == 8'd0);
  assign dl_rise = ioctl_download && !download_d;
  assign dl_fall = !ioctl_download && download_d;

  // Only one port is ever in flight, so a single handshake pair is tracked.
  assign cur_req = sel_p2 ? port2_req : port1_req;
  assign cur_ack = sel_p2 ? port2_ack : port1_ack;

  assign ioctl_wait = (state != IDLE);

  always_ff @(posedge clk_mem or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    go_dl      = 1'b0;
    go_p1      = 1'b0;
    go_p2      = 1'b0;
    do_issue   = 1'b0;
    do_abandon = 1'b0;
    proto_err  = 1'b0;
    case (state)
      IDLE: begin
        if (wr_take) begin
          if (in_dl) begin
            go_dl = 1'b1;
          end else if (in_p1) begin
            go_p1     = 1'b1;
            state_nxt = ISSUE;
          end else if (in_p2) begin
            go_p2     = 1'b1;
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        do_issue  = 1'b1;
        state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (cur_ack == cur_req) begin
          state_nxt = IDLE;
        end else if (to_cnt == TO_LAST) begin
          do_abandon = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // HPS must not strobe while ioctl_wait is high; such a byte is lost.
    if (wr_take && (state != IDLE)) begin
      proto_err = 1'b1;
    end
  end

  always_ff @(posedge clk_mem or negedge reset_n) begin
    if (!reset_n) begin
      wr_d       <= 1'b0;
      download_d <= 1'b0;
      sel_p2     <= 1'b0;
      to_cnt     <= 8'd0;
      port1_req  <= 1'b0;
      port1_a    <= 23'd0;
      port1_ds   <= 2'd0;
      port1_d    <= 16'd0;
      port2_req  <= 1'b0;
      port2_a    <= 23'd0;
      port2_ds   <= 2'd0;
      port2_d    <= 16'd0;
      dl_addr    <= 17'd0;
      dl_data    <= 8'd0;
      dl_wr      <= 1'b0;
      load_err   <= 1'b0;
      rom_loaded <= 1'b0;
      end_pend   <= 1'b0;
    end else begin
      wr_d       <= ioctl_wr;
      download_d <= ioctl_download;
      dl_wr      <= go_dl;

      if (go_dl) begin
        dl_addr <= a;
        dl_data <= ioctl_dout;
      end

      if (go_p1) begin
        sel_p2   <= 1'b0;
        port1_a  <= ioctl_addr[23:1];
        port1_ds <= {a[0], ~a[0]};
        port1_d  <= {ioctl_dout, ioctl_dout};
      end

      // Sprite data is re-interleaved: bit 15 becomes the word LSB and
      // bit 14 selects the byte lane.
      if (go_p2) begin
        sel_p2   <= 1'b1;
        port2_a  <= {s[23:16], s[13:0], s[15]};
        port2_ds <= {s[14], ~s[14]};
        port2_d  <= {ioctl_dout, ioctl_dout};
      end

      if (do_issue) begin
        to_cnt <= 8'd0;
        if (sel_p2) port2_req <= ~port2_req;
        else        port1_req <= ~port1_req;
      end else if (state == WAIT_ACK) begin
        to_cnt <= to_cnt + 8'd1;
      end

      // Abandon: realign req with ack so the port looks idle again.
      if (do_abandon) begin
        if (sel_p2) port2_req <= port2_ack;
        else        port1_req <= port1_ack;
      end

      if (dl_rise) load_err <= 1'b0;
      if (do_abandon || proto_err) load_err <= 1'b1;

      // rom_loaded waits for any in-flight write to retire after download ends.
      if (dl_rise) begin
        rom_loaded <= 1'b0;
        end_pend   <= 1'b0;
      end else begin
        if (dl_fall) end_pend <= 1'b1;
        if (!ioctl_download && (state == IDLE) && end_pend) begin
          rom_loaded <= 1'b1;
          end_pend   <= 1'b0;
        end
      end
    end
  end

`ifdef TROPANG_LOADER_CHECKSUM_EN
  always_ff @(posedge clk_mem or negedge reset_n) begin
    if (!reset_n) begin
      checksum <= 16'd0;
    end else if (dl_rise) begin
      checksum <= wr_take ? {8'h00, ioctl_dout} : 16'd0;
    end else if (wr_take) begin
      checksum <= checksum + {8'h00, ioctl_dout};
    end
  end
`endif

endmodule

// File: tb/tb_tropang_rom_loader.sv
// Purpose : scoreboard bench for tropang_rom_loader; stimulus pushes expected port/dl events, a monitor pops them.
// Latency : monitor samples on the falling clock edge, stimulus drives 1 time unit after the rising edge.
// Backpr. : every wait on the DUT is bounded; a watchdog ends the run with a FAIL line if anything hangs.
module tb_tropang_rom_loader;

  localparam int K_P1 = 1, K_P2 = 2, K_DL = 3, K_AB1 = 4, K_AB2 = 5;
  localparam int LIM  = 600;

  logic        clk_mem = 1'b0;
  logic        reset_n;
  logic        ioctl_download, ioctl_wr, ioctl_wait;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout, ioctl_index;
  logic        port1_req, port1_ack, port2_req, port2_ack;
  logic [22:0] port1_a, port2_a;
  logic [1:0]  port1_ds, port2_ds;
  logic [15:0] port1_d, port2_d;
  logic [16:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_wr, rom_loaded, load_err;
`ifdef TROPANG_LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  typedef struct {
    int          kind;
    logic [24:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b1;
  bit  ack1_en = 1'b1, ack2_en = 1'b1;
  int  ack1_dly = 4, ack2_dly = 1;

  always #5 clk_mem = ~clk_mem;

  tropang_rom_loader #(.ACK_TIMEOUT(255)) dut (
    .clk_mem(clk_mem), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait),
    .port1_req(port1_req), .port1_ack(port1_ack), .port1_a(port1_a),
    .port1_ds(port1_ds), .port1_d(port1_d),
    .port2_req(port2_req), .port2_ack(port2_ack), .port2_a(port2_a),
    .port2_ds(port2_ds), .port2_d(port2_d),
    .dl_addr(dl_addr), .dl_data(dl_data), .dl_wr(dl_wr),
    .rom_loaded(rom_loaded), .load_err(load_err)
`ifdef TROPANG_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input int kind, input logic [24:0] a, input logic [1:0] ds, input logic [15:0] d);
    ev_t e;
    e.kind = kind; e.a = a; e.ds = ds; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic mon_evt(input int kind, input logic [24:0] a, input logic [1:0] ds, input logic [15:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d a=%0h ds=%0h d=%0h required=none", kind, a, ds, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.a !== a || e.ds !== ds || e.d !== d) begin
        errors++;
        $display("FAIL event actual kind=%0d a=%0h ds=%0h d=%0h required kind=%0d a=%0h ds=%0h d=%0h",
                 kind, a, ds, d, e.kind, e.a, e.ds, e.d);
      end
    end
  endtask

  // Monitor: a req change away from ack is a new request, back onto ack is an abandon.
  initial begin
    logic p1_prev, p2_prev;
    p1_prev = 1'b0;
    p2_prev = 1'b0;
    forever begin
      @(negedge clk_mem);
      if (mon_en) begin
        if (dl_wr === 1'b1)
          mon_evt(K_DL, {8'h00, dl_addr}, 2'b00, {8'h00, dl_data});
        if (port1_req !== p1_prev)
          mon_evt((port1_req !== port1_ack) ? K_P1 : K_AB1, {2'b00, port1_a}, port1_ds, port1_d);
        if (port2_req !== p2_prev)
          mon_evt((port2_req !== port2_ack) ? K_P2 : K_AB2, {2'b00, port2_a}, port2_ds, port2_d);
      end
      p1_prev = port1_req;
      p2_prev = port2_req;
    end
  end

  // SDRAM ack responders: ack follows req ackN_dly cycles after the toggle is seen.
  initial begin
    port1_ack = 1'b0;
    forever begin
      @(posedge clk_mem); #1;
      if (!reset_n) port1_ack = 1'b0;
      else if (ack1_en && port1_req !== port1_ack) begin
        repeat (ack1_dly) @(posedge clk_mem);
        #1;
        if (!reset_n) port1_ack = 1'b0;
        else if (ack1_en) port1_ack = port1_req;
      end
    end
  end

  initial begin
    port2_ack = 1'b0;
    forever begin
      @(posedge clk_mem); #1;
      if (!reset_n) port2_ack = 1'b0;
      else if (ack2_en && port2_req !== port2_ack) begin
        repeat (ack2_dly) @(posedge clk_mem);
        #1;
        if (!reset_n) port2_ack = 1'b0;
        else if (ack2_en) port2_ack = port2_req;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not complete, required finish");
    $fatal(1, "watchdog");
  end

  // Leaves the caller 1 time unit after the edge that samples the rise (cycle N).
  task automatic wr_byte(input logic [24:0] addr, input logic [7:0] dat);
    @(posedge clk_mem); #1;
    ioctl_addr = addr;
    ioctl_dout = dat;
    ioctl_wr   = 1'b1;
    @(posedge clk_mem); #1;
    ioctl_wr   = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (ioctl_wait && n < LIM) begin
      @(posedge clk_mem); #1;
      n++;
    end
  endtask

  task automatic cycles(input int k);
    repeat (k) @(posedge clk_mem);
    #1;
  endtask

  initial begin
    int n, k;
    reset_n = 1'b1;
    ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; ioctl_index = 8'd0;
    #1 reset_n = 1'b0;
    #2;
    check("rst_wait",       ioctl_wait, 0);
    check("rst_reqs",       {port1_req, port2_req}, 0);
    check("rst_dl_wr",      dl_wr, 0);
    check("rst_status",     {rom_loaded, load_err}, 0);
    check("rst_regs",       {port1_a, port1_ds, port1_d, port2_a, port2_ds, port2_d, dl_addr, dl_data}, 0);
    repeat (3) @(posedge clk_mem);
    #3 reset_n = 1'b1;
    cycles(1);
    ioctl_download = 1'b1;
    cycles(2);

    // port 1, ack 4 cycles after req toggle
    ack1_dly = 4;
    push(K_P1, 25'h000001, 2'b10, 16'h5A5A);
    wr_byte(25'h00003, 8'h5A);
    check("p1_wait_n1", ioctl_wait, 1);
    wait_idle(n);
    check("p1_wait_cycles", n, 6);
    check("p1_port2_untouched", port2_req, 0);

    // port 2, quickest ack -> 3-cycle turnaround
    ack2_dly = 1;
    push(K_P2, 25'h000002, 2'b10, 16'hC3C3);
    wr_byte(25'h14001, 8'hC3);
    wait_idle(n);
    check("p2_min_turnaround", n, 3);

    // region edges
    push(K_P2, 25'h007FFF, 2'b01, 16'h7777);
    wr_byte(25'h1BFFF, 8'h77);
    wait_idle(n);
    check("p2_top_idle", n < LIM, 1);
    push(K_P1, 25'h004FFF, 2'b10, 16'h9999);
    wr_byte(25'h09FFF, 8'h99);
    wait_idle(n);
    check("p1_top_idle", n < LIM, 1);
    push(K_P1, 25'h000000, 2'b01, 16'h0101);
    wr_byte(25'h00000, 8'h01);
    wait_idle(n);
    check("p1_base_idle", n < LIM, 1);

    // dl bus regions
    push(K_DL, 25'h0A000, 2'b00, 16'h0011);
    wr_byte(25'h0A000, 8'h11);
    check("dl_wr_n1", dl_wr, 1);
    check("dl_no_wait", ioctl_wait, 0);
    push(K_DL, 25'h1C31F, 2'b00, 16'h0022);
    wr_byte(25'h1C31F, 8'h22);
    push(K_DL, 25'h0FFFF, 2'b00, 16'h0033);
    wr_byte(25'h0FFFF, 8'h33);
    push(K_DL, 25'h1C000, 2'b00, 16'h0044);
    wr_byte(25'h1C000, 8'h44);

    // dropped bytes: above palette, upper address bits, wrong index
    wr_byte(25'h1C320, 8'h55);
    check("drop_no_wait", ioctl_wait, 0);
    wr_byte(25'h1FFFF, 8'h56);
    wr_byte(25'h20000, 8'h57);
    ioctl_index = 8'd1;
    wr_byte(25'h0A001, 8'h58);
    ioctl_index = 8'd0;
    cycles(3);
    check("dl_addr_hold", {dl_addr, dl_data}, {17'h1C000, 8'h44});
    check("drop_no_events", exp_q.size(), 0);

    // ack timeout: abandon brings req back onto ack
    ack1_en = 1'b0;
    push(K_P1, 25'h000008, 2'b01, 16'hABAB);
    push(K_AB1, 25'h000008, 2'b01, 16'hABAB);
    wr_byte(25'h00010, 8'hAB);
    cycles(1);
    k = 0;
    while (!load_err && k < 400) begin
      cycles(1);
      k++;
    end
    check("timeout_cycles", k, 255);
    check("timeout_fsm_idle", ioctl_wait, 0);
    check("timeout_req_eq_ack", port1_req ^ port1_ack, 0);
    ack1_en = 1'b1;
    cycles(3);
    check("load_err_sticky", load_err, 1);
    ioctl_download = 1'b0;
    cycles(3);
    check("rom_loaded_idle_end", rom_loaded, 1);
    ioctl_download = 1'b1;
    cycles(1);
    check("load_err_cleared", load_err, 0);
    check("rom_loaded_cleared", rom_loaded, 0);

    // strobe while ioctl_wait is high: byte dropped, load_err set
    ack1_dly = 8;
    push(K_P1, 25'h000002, 2'b01, 16'h5555);
    wr_byte(25'h00004, 8'h55);
    cycles(1);
    ioctl_addr = 25'h0A001; ioctl_dout = 8'hEE; ioctl_wr = 1'b1;
    cycles(1);
    ioctl_wr = 1'b0;
    check("proto_err", load_err, 1);
    wait_idle(n);
    check("proto_wait_cycles", n, 8);
    ioctl_download = 1'b0;
    cycles(3);
    ioctl_download = 1'b1;
    cycles(2);

    // download ends mid-write: rom_loaded follows the retire
    ack1_dly = 6;
    push(K_P1, 25'h000003, 2'b01, 16'h6666);
    wr_byte(25'h00006, 8'h66);
    cycles(1);
    ioctl_download = 1'b0;
    wait_idle(n);
    check("late_end_wait_cycles", n, 7);
    check("rom_loaded_not_early", rom_loaded, 0);
    cycles(1);
    check("rom_loaded_after_idle", rom_loaded, 1);
    ioctl_download = 1'b1;
    cycles(2);
    check("rom_loaded_restart", rom_loaded, 0);

    // async reset in the middle of a write
    mon_en = 1'b0;
    ack1_en = 1'b0;
    wr_byte(25'h00008, 8'h88);
    cycles(1);
    #2 reset_n = 1'b0;
    #1;
    check("reset_midwrite", {ioctl_wait, port1_req, port2_req, dl_wr, rom_loaded, load_err,
                             port1_a, port1_ds, port1_d, port2_a, port2_ds, port2_d,
                             dl_addr, dl_data}, 0);
    repeat (2) @(posedge clk_mem);
    #3 reset_n = 1'b1;
    cycles(2);
    mon_en = 1'b1;
    ack1_en = 1'b1;
    ack1_dly = 4;

    push(K_P1, 25'h000000, 2'b10, 16'hE1E1);
    wr_byte(25'h00001, 8'hE1);
    wait_idle(n);
    check("post_reset_wait_cycles", n, 6);

`ifdef TROPANG_LOADER_CHECKSUM_EN
    ioctl_download = 1'b0;
    cycles(2);
    ioctl_download = 1'b1;
    cycles(2);
    wr_byte(25'h1C320, 8'hFF);
    wr_byte(25'h20000, 8'hFF);
    wr_byte(25'h1C321, 8'h03);
    cycles(1);
    check("checksum", checksum, 16'h0201);
`endif

    cycles(5);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tropang_rom_loader.md
# tropang_rom_loader

ROM download sequencer between the HPS ioctl stream and the game's memories. It decodes each downloaded byte against the Tropical Angel ROM map. CPU and sound bytes go to SDRAM port 1, sprite bytes to SDRAM port 2, and gfx1 and palette/LUT bytes to the on-chip `dl_*` bus. It holds `ioctl_wait` while an SDRAM write is outstanding, and it raises `rom_loaded` once the last write has retired.

## Interface
- `ACK_TIMEOUT`, default 255: number of cycles to wait for an SDRAM ack before aborting a write (8-bit counter).
- `clk_mem` in, 1 bit: single clock. All ioctl and SDRAM port signals are synchronous to it.
- `reset_n` in, 1 bit: asynchronous, active-low reset.
- `ioctl_download` in, 1 bit: download in progress.
- `ioctl_wr` in, 1 bit: byte strobe; writes are taken on its rising edge.
- `ioctl_addr` in, 25 bits: byte address.
- `ioctl_dout` in, 8 bits: byte data.
- `ioctl_index` in, 8 bits: only index 0 is accepted.
- `ioctl_wait` out, 1 bit: backpressure to HPS.
- `port1_req` out, 1 bit: toggle request.
- `port1_ack` in, 1 bit: toggle ack.
- `port1_a` out, 23 bits: port 1 word address.
- `port1_ds` out, 2 bits: port 1 byte enables.
- `port1_d` out, 16 bits: port 1 write data.
- `port2_req`, `port2_ack`, `port2_a` [22:0], `port2_ds` [1:0], `port2_d` [15:0]: same as port 1, for port 2.
- `dl_addr` out, 17 bits; `dl_data` out, 8 bits; `dl_wr` out, 1 bit: on-chip write bus.
- `rom_loaded` out, 1 bit: every byte of the last download has been written.
- `load_err` out, 1 bit: sticky flag, set by an ack timeout.

## Operation
- Edge detect: `wr_rise = ioctl_wr & ~ioctl_wr_d`. The edge is ignored unless `ioctl_download` is high and `ioctl_index` is 0.
- Decode uses `a = ioctl_addr[16:0]`. Bytes with `ioctl_addr[24:17] != 0` are dropped.
  - 0x00000–0x09FFF → port 1:
    - `port1_a = ioctl_addr[23:1]`
    - `port1_ds = {a[0], ~a[0]}`
    - `port1_d = {dout, dout}`
  - 0x0A000–0x0FFFF → `dl` bus.
  - 0x10000–0x1BFFF → port 2, with `s = ioctl_addr - 0x10000`:
    - `port2_a = {s[23:16], s[13:0], s[15]}`
    - `port2_ds = {s[14], ~s[14]}`
    - `port2_d = {dout, dout}`
  - 0x1C000–0x1C31F → `dl` bus.
  - 0x1C320 and above → dropped. No write and no wait.
- FSM states are IDLE, ISSUE, WAIT_ACK.
  - IDLE: on an accepted edge:
    - `dl` region: pulse `dl_wr`, stay in IDLE.
    - SDRAM region: latch address, enables and data into the selected port's registers, go to ISSUE.
  - ISSUE: toggle the selected `portN_req`, clear the timeout counter, go to WAIT_ACK.
  - WAIT_ACK: return to IDLE when `portN_ack == portN_req`. If the counter reaches `ACK_TIMEOUT` first:
    - set `load_err`;
    - force the `req` register equal to the sampled `ack`, so the pending request is abandoned;
    - go to IDLE.
- Only one port is in flight at a time. The other port's `req` does not change.
- An edge arriving in ISSUE or WAIT_ACK is a protocol violation, because `ioctl_wait` is high. That byte is dropped and `load_err` is set.
- `rom_loaded`:
  - cleared on the rising edge of `ioctl_download`;
  - set on the first cycle where `ioctl_download` is low, the FSM is in IDLE, and a download-ended flag is pending;
  - the flag is set by the falling edge of `ioctl_download`.
- `load_err` is cleared on the rising edge of `ioctl_download`.
- If `ioctl_download` falls mid-write, the write still completes. `rom_loaded` then follows.

## Timing
- Reset values:
  - `ioctl_wait`, `port1_req`, `port2_req`, `dl_wr`, `rom_loaded`, `load_err` = 0.
  - All address and data registers = 0.
  - FSM = IDLE.
- The `ioctl_wr` rise is sampled at cycle N.
  - `dl` region: `dl_addr`, `dl_data` valid and `dl_wr` = 1 at cycle N+1, for exactly one cycle. `dl_addr`/`dl_data` then hold until the next write.
  - SDRAM region:
    - N+1: port registers valid, `ioctl_wait` = 1.
    - N+2: `req` toggles.
    - Address, enables and data are stable from N+1 until the ack is seen.
    - `ioctl_wait` falls in the cycle after `ack == req` is observed.
- Minimum SDRAM write turnaround: 3 cycles with an immediate ack.
- Timeout: `load_err` is set `ACK_TIMEOUT` cycles after the `req` toggle.

## Configuration
- `TROPANG_LOADER_CHECKSUM_EN` defined:
  - adds output `checksum` [15:0], the mod-2^16 sum of all accepted bytes, including dropped-region bytes;
  - cleared on the rising edge of `ioctl_download`;
  - updated at N+1.
- Without the macro: no `checksum` port and no adder logic. All other behaviour is identical.

## Test plan
- Write 0x5A at 0x00003 → `port1_a` = 0x000001, `ds` = 2'b10, `d` = 0x5A5A. `req` toggles at N+2; ack after 4 cycles → `ioctl_wait` high for 6 cycles. Port 2 untouched.
- Write 0xC3 at 0x14001 → `s` = 0x4001 → `port2_a` = {8'h00, 14'h0001, 1'b0} = 0x000002, `ds` = 2'b10, `d` = 0xC3C3.
- Write 0x11 at 0x0A000, then 0x22 at 0x1C31F → `dl_wr` pulses with `dl_addr` 0x0A000 / 0x1C31F. No `req` toggles, `ioctl_wait` stays 0. A write at 0x1C320 produces no output.
- Never return ack → `load_err` = 1 after 255 cycles, FSM in IDLE. The next download start clears `load_err`.
- Drop `ioctl_download` while in WAIT_ACK, then ack → `rom_loaded` rises in the cycle after the FSM returns to IDLE. `reset_n` low mid-write → all outputs at reset values immediately.
- With the macro defined, download bytes 0xFF, 0xFF, 0x03 → `checksum` = 0x0201.
